race_controller: RTL and testbench

Top-level race sequencer: produces the 3-bit `state` code that drives every PhysicsEngine instance and the HUD. It owns the countdown, the race timer and the lap counter, and makes all transitions from player button pulses and checkpoint lap pulses. It sits between the input/debounce logic and the per-car physics and display blocks.

---
 rtl/race_controller.sv | 174 +++++++++++++++++
 tb/tb_race_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// Race sequencer: IDLE -> SETTING -> COUNTDOWN -> RACING <-> PAUSE -> FINISH.
// Optional RACE_TIMEOUT_EN ends the race when the timer reaches MAX_TIME.
module race_controller #(
    parameter int SEC_DIV    = 100_000_000,
    parameter int COUNT_SECS = 3,
    parameter int TOTAL_LAPS = 3,
    parameter int MAX_TIME   = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       lap_pulse,
    output logic [2:0] state,
    output logic [2:0] countdown,
    output logic [3:0] lap_count,
    output logic [9:0] race_time,
    output logic       go_pulse,
    output logic       done_pulse,
    output logic       timeout
);

    localparam int             PW         = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SEC_DIV - 1);
    localparam logic [2:0]     CD_INIT    = 3'(COUNT_SECS);
    localparam logic [3:0]     LAPS_END   = 4'(TOTAL_LAPS);
    localparam logic [9:0]     TIME_MAX   = 10'(MAX_TIME);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTING   = 3'd1,
        ST_COUNTDOWN = 3'd3,
        ST_RACING    = 3'd4,
        ST_PAUSE     = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    state_t          state_q,     state_d;
    logic [PW-1:0]   presc_q,     presc_d;
    logic [2:0]      countdown_q, countdown_d;
    logic [3:0]      lap_q,       lap_d;
    logic [9:0]      time_q,      time_d;
    logic            go_q,        go_d;
    logic            done_q,      done_d;
    logic            timeout_q,   timeout_d;

    logic            counting;
    logic            sec_tick;
    logic [3:0]      lap_inc;
    logic            lap_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            countdown_q <= '0;
            lap_q       <= '0;
            time_q      <= '0;
            go_q        <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            countdown_q <= countdown_d;
            lap_q       <= lap_d;
            time_q      <= time_d;
            go_q        <= go_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        countdown_d = countdown_q;
        lap_d       = lap_q;
        time_d      = time_q;
        go_d        = 1'b0;
        done_d      = 1'b0;
`ifdef RACE_TIMEOUT_EN
        timeout_d   = timeout_q;
`else
        timeout_d   = 1'b0;
`endif

        counting = (state_q == ST_COUNTDOWN) || (state_q == ST_RACING);
        sec_tick = counting && (presc_q == PRESC_LAST);
        lap_inc  = lap_q + 4'd1;
        lap_done = (lap_inc == LAPS_END);

        // Prescaler only advances while a countdown or race is live.
        if (counting) begin
            presc_d = sec_tick ? '0 : presc_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_SETTING;
                end
            end
            ST_SETTING: begin
                if (btn_start) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = CD_INIT;
                    presc_d     = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (sec_tick) begin
                    countdown_d = countdown_q - 3'd1;
                    if (countdown_q == 3'd1) begin
                        state_d = ST_RACING;
                        presc_d = '0;
                        time_d  = '0;
                        lap_d   = '0;
                        go_d    = 1'b1;
                    end
                end
            end
            ST_RACING: begin
                if (sec_tick && (time_q < TIME_MAX)) begin
                    time_d = time_q + 10'd1;
                end
                if (lap_pulse) begin
                    lap_d = lap_inc;
                end
                // A finishing lap outranks the timer, which outranks pause.
                if (lap_pulse && lap_done) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end
`ifdef RACE_TIMEOUT_EN
                else if (sec_tick && (time_q < TIME_MAX) && ((time_q + 10'd1) == TIME_MAX)) begin
                    state_d   = ST_FINISH;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
                else if (btn_pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (btn_pause) begin
                    state_d = ST_RACING;
                end
            end
            ST_FINISH: begin
                if (btn_start) begin
                    state_d     = ST_IDLE;
                    time_d      = '0;
                    lap_d       = '0;
                    countdown_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state      = state_q;
    assign countdown  = countdown_q;
    assign lap_count  = lap_q;
    assign race_time  = time_q;
    assign go_pulse   = go_q;
    assign done_pulse = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller with SEC_DIV=4, COUNT_SECS=3, TOTAL_LAPS=2, MAX_TIME=5.
module tb_race_controller;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_pause;
    logic       lap_pulse;
    logic [2:0] state;
    logic [2:0] countdown;
    logic [3:0] lap_count;
    logic [9:0] race_time;
    logic       go_pulse;
    logic       done_pulse;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    race_controller #(
        .SEC_DIV   (4),
        .COUNT_SECS(3),
        .TOTAL_LAPS(2),
        .MAX_TIME  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .lap_pulse (lap_pulse),
        .state     (state),
        .countdown (countdown),
        .lap_count (lap_count),
        .race_time (race_time),
        .go_pulse  (go_pulse),
        .done_pulse(done_pulse),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        btn_start = 1'b1; tick(1); btn_start = 1'b0;
    endtask

    task automatic pulse_pause();
        btn_pause = 1'b1; tick(1); btn_pause = 1'b0;
    endtask

    task automatic pulse_lap();
        lap_pulse = 1'b1; tick(1); lap_pulse = 1'b0;
    endtask

    // From IDLE, ends on the first RACING cycle.
    task automatic start_race();
        pulse_start();
        pulse_start();
        tick(12);
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; lap_pulse = 1'b0;
        tick(2);
        total++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
        total++; if ({countdown, lap_count, race_time} !== 17'd0)
            $display("FAIL reset_counters got cd=%0d lap=%0d time=%0d want 0", countdown, lap_count, race_time); else passed++;
        total++; if ({go_pulse, done_pulse, timeout} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {go_pulse, done_pulse, timeout}); else passed++;
        rst = 1'b1;
        tick(1);
        pulse_lap();
        pulse_pause();
        total++; if (state !== 3'd0) $display("FAIL idle_ignores got %0d want 0", state); else passed++;
    endtask

    task automatic test_countdown();
        pulse_start();
        total++; if (state !== 3'd1) $display("FAIL setting_state got %0d want 1", state); else passed++;
        pulse_start();
        total++; if (state !== 3'd3 || countdown !== 3'd3)
            $display("FAIL countdown_entry got st=%0d cd=%0d want 3/3", state, countdown); else passed++;
        pulse_lap();
        total++; if (lap_count !== 4'd0) $display("FAIL lap_in_countdown got %0d want 0", lap_count); else passed++;
        tick(3);
        total++; if (countdown !== 3'd2) $display("FAIL countdown_2 got %0d want 2", countdown); else passed++;
        tick(4);
        total++; if (countdown !== 3'd1) $display("FAIL countdown_1 got %0d want 1", countdown); else passed++;
        tick(3);
        total++; if (state !== 3'd3 || go_pulse !== 1'b0)
            $display("FAIL before_go got st=%0d go=%b want 3/0", state, go_pulse); else passed++;
        tick(1);
        total++; if (state !== 3'd4 || go_pulse !== 1'b1 || countdown !== 3'd0)
            $display("FAIL go got st=%0d go=%b cd=%0d want 4/1/0", state, go_pulse, countdown); else passed++;
    endtask

    task automatic test_pause();
        tick(1);
        total++; if (go_pulse !== 1'b0) $display("FAIL go_one_cycle got %b want 0", go_pulse); else passed++;
        tick(3);
        total++; if (race_time !== 10'd1) $display("FAIL race_time_1 got %0d want 1", race_time); else passed++;
        tick(5);
        total++; if (race_time !== 10'd2) $display("FAIL race_time_2 got %0d want 2", race_time); else passed++;
        pulse_pause();
        total++; if (state !== 3'd5) $display("FAIL pause_enter got %0d want 5", state); else passed++;
        pulse_lap();
        tick(19);
        total++; if (race_time !== 10'd2 || lap_count !== 4'd0)
            $display("FAIL pause_hold got time=%0d lap=%0d want 2/0", race_time, lap_count); else passed++;
        pulse_pause();
        total++; if (state !== 3'd4) $display("FAIL pause_exit got %0d want 4", state); else passed++;
        tick(1);
        total++; if (race_time !== 10'd2) $display("FAIL resume_hold got %0d want 2", race_time); else passed++;
        tick(1);
        total++; if (race_time !== 10'd3) $display("FAIL resume_count got %0d want 3", race_time); else passed++;
    endtask

    task automatic test_laps();
        pulse_lap();
        total++; if (lap_count !== 4'd1 || state !== 3'd4)
            $display("FAIL lap_1 got lap=%0d st=%0d want 1/4", lap_count, state); else passed++;
        pulse_lap();
        total++; if (lap_count !== 4'd2 || state !== 3'd6 || done_pulse !== 1'b1)
            $display("FAIL finish got lap=%0d st=%0d done=%b want 2/6/1", lap_count, state, done_pulse); else passed++;
        tick(6);
        total++; if (done_pulse !== 1'b0 || race_time !== 10'd3 || state !== 3'd6)
            $display("FAIL finish_hold got done=%b time=%0d st=%0d want 0/3/6", done_pulse, race_time, state); else passed++;
        pulse_start();
        total++; if (state !== 3'd0 || lap_count !== 4'd0 || race_time !== 10'd0)
            $display("FAIL finish_exit got st=%0d lap=%0d time=%0d want 0/0/0", state, lap_count, race_time); else passed++;
    endtask

    task automatic test_simultaneous();
        start_race();
        lap_pulse = 1'b1; btn_pause = 1'b1; tick(1); lap_pulse = 1'b0; btn_pause = 1'b0;
        total++; if (lap_count !== 4'd1 || state !== 3'd5)
            $display("FAIL lap_pause got lap=%0d st=%0d want 1/5", lap_count, state); else passed++;
        pulse_pause();
        lap_pulse = 1'b1; btn_pause = 1'b1; tick(1); lap_pulse = 1'b0; btn_pause = 1'b0;
        total++; if (lap_count !== 4'd2 || state !== 3'd6 || done_pulse !== 1'b1)
            $display("FAIL final_lap_pause got lap=%0d st=%0d done=%b want 2/6/1", lap_count, state, done_pulse); else passed++;
        pulse_start();
        total++; if (state !== 3'd0) $display("FAIL sim_exit got %0d want 0", state); else passed++;
    endtask

    task automatic test_async_reset();
        start_race();
        pulse_lap();
        tick(5);
        total++; if (race_time !== 10'd1 || lap_count !== 4'd1)
            $display("FAIL pre_reset got time=%0d lap=%0d want 1/1", race_time, lap_count); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({state, countdown, lap_count, race_time, go_pulse, done_pulse, timeout} !== 23'd0)
            $display("FAIL async_reset got st=%0d lap=%0d time=%0d want 0", state, lap_count, race_time); else passed++;
        #1 rst = 1'b1;
        tick(2);
        total++; if (state !== 3'd0) $display("FAIL post_reset got %0d want 0", state); else passed++;
    endtask

    task automatic test_timeout();
        start_race();
        tick(19);
        total++; if (race_time !== 10'd4 || state !== 3'd4)
            $display("FAIL pre_max got time=%0d st=%0d want 4/4", race_time, state); else passed++;
        tick(1);
`ifdef RACE_TIMEOUT_EN
        total++; if (state !== 3'd6 || done_pulse !== 1'b1 || timeout !== 1'b1)
            $display("FAIL timeout_finish got st=%0d done=%b to=%b want 6/1/1", state, done_pulse, timeout); else passed++;
`else
        total++; if (state !== 3'd4 || done_pulse !== 1'b0 || timeout !== 1'b0)
            $display("FAIL no_timeout got st=%0d done=%b to=%b want 4/0/0", state, done_pulse, timeout); else passed++;
`endif
        tick(4);
`ifdef RACE_TIMEOUT_EN
        total++; if (race_time !== 10'd5 || state !== 3'd6 || timeout !== 1'b1)
            $display("FAIL timeout_hold got time=%0d st=%0d to=%b want 5/6/1", race_time, state, timeout); else passed++;
        pulse_start();
        total++; if (state !== 3'd0 || timeout !== 1'b0 || race_time !== 10'd0)
            $display("FAIL timeout_clear got st=%0d to=%b time=%0d want 0/0/0", state, timeout, race_time); else passed++;
`else
        total++; if (race_time !== 10'd5 || state !== 3'd4 || timeout !== 1'b0)
            $display("FAIL saturate got time=%0d st=%0d to=%b want 5/4/0", race_time, state, timeout); else passed++;
        tick(8);
        total++; if (race_time !== 10'd5) $display("FAIL saturate_hold got %0d want 5", race_time); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_laps();
        test_simultaneous();
        test_async_reset();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
